// File: rtl/inter_layer_block_scheduler_pkg.sv
// Shared encodings for the inter-layer block scheduler: block pairing types and FSM states.
package inter_layer_block_scheduler_pkg;

  typedef enum logic [1:0] {
    FORWARD_FORWARD   = 2'd0,
    FORWARD_BACKWARD  = 2'd1,
    BACKWARD_FORWARD  = 2'd2,
    BACKWARD_BACKWARD = 2'd3
  } block_type_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad0 = 3'd1,
    StLoad1 = 3'd2,
    StCalc  = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [31:0] BubbleSat = 32'hFFFF_FFFF;

endpackage

// File: rtl/inter_layer_block_scheduler_bubble_estimator.sv
// Combinational bubble estimate: |w0*cim - w1*npu| saturated to 32 bits, compared to threshold.
module inter_layer_block_scheduler_bubble_estimator
  import inter_layer_block_scheduler_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [31:0] npu_cap_i,
  input  logic [31:0] cim_cap_i,
  input  logic [31:0] threshold_i,
  output logic [31:0] bubble_o,
  output logic        overlap_o
);

  logic [63:0] p0;
  logic [63:0] p1;
  logic [63:0] diff;
  logic [31:0] bubble;

  always_comb begin
    // block0 boundary runs on the CIM, block1 boundary on the NPU
    p0        = {32'd0, w0_i} * {32'd0, cim_cap_i};
    p1        = {32'd0, w1_i} * {32'd0, npu_cap_i};
    diff      = (p0 >= p1) ? (p0 - p1) : (p1 - p0);
    bubble    = (diff[63:32] != 32'd0) ? BubbleSat : diff[31:0];
    bubble_o  = bubble;
    overlap_o = (bubble <= threshold_i);
  end

endmodule

// File: rtl/inter_layer_block_scheduler.sv
// Fetches one workload word per block from config memory and reports whether the blocks may overlap.
module inter_layer_block_scheduler
  import inter_layer_block_scheduler_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] npu_capability_i,
  input  logic [31:0] in_pipeline_cim_capability_i,
  input  logic [31:0] bubble_threshold_i,
  output logic [31:0] config_mem_addr_o,
  output logic        config_mem_read_valid_o,
  input  logic [31:0] config_mem_read_data_i,
  input  logic        config_mem_read_ready_i,
  input  logic [1:0]  block_type_i,
  input  logic [31:0] block0_start_i,
  input  logic [31:0] block1_start_i,
  input  logic [31:0] block0_length_i,
  input  logic [31:0] block1_length_i,
  input  logic        schedule_valid_i,
  output logic        schedule_ready_o,
  output logic        result_valid_o,
  output logic        overlap_o,
  output logic [31:0] bubble_o
);

  state_e      state_q, state_d;
  block_type_e type_q;
  logic [31:0] start0_q, start1_q;
  logic [31:0] len0_q, len1_q;
  logic [31:0] npu_q, cim_q, thr_q;
  logic [31:0] w0_q, w1_q;
  logic [31:0] bubble_q;
  logic        overlap_q;

  logic [31:0] est_bubble;
  logic        est_overlap;

  logic accept, load0_fire, load1_fire;

  assign accept     = (state_q == StIdle) && schedule_valid_i;
  assign load0_fire = (state_q == StLoad0) && config_mem_read_ready_i;
  assign load1_fire = (state_q == StLoad1) && config_mem_read_ready_i;

  // Block type and lengths are captured for future use but do not yet steer the decision.
  logic unused_latched;
  assign unused_latched = ^{type_q, len0_q, len1_q};

  inter_layer_block_scheduler_bubble_estimator u_bubble_estimator (
    .w0_i        (w0_q),
    .w1_i        (w1_q),
    .npu_cap_i   (npu_q),
    .cim_cap_i   (cim_q),
    .threshold_i (thr_q),
    .bubble_o    (est_bubble),
    .overlap_o   (est_overlap)
  );

  always_comb begin
    state_d                 = state_q;
    schedule_ready_o        = 1'b0;
    config_mem_read_valid_o = 1'b0;
    config_mem_addr_o       = 32'd0;
    result_valid_o          = 1'b0;
    unique case (state_q)
      StIdle: begin
        schedule_ready_o = 1'b1;
        if (schedule_valid_i) state_d = StLoad0;
      end
      StLoad0: begin
        config_mem_read_valid_o = 1'b1;
        config_mem_addr_o       = start0_q;
        if (config_mem_read_ready_i) state_d = StLoad1;
      end
      StLoad1: begin
        config_mem_read_valid_o = 1'b1;
        config_mem_addr_o       = start1_q;
        if (config_mem_read_ready_i) state_d = StCalc;
      end
      StCalc: state_d = StDone;
      StDone: begin
        result_valid_o = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      type_q    <= FORWARD_FORWARD;
      start0_q  <= 32'd0;
      start1_q  <= 32'd0;
      len0_q    <= 32'd0;
      len1_q    <= 32'd0;
      npu_q     <= 32'd0;
      cim_q     <= 32'd0;
      thr_q     <= 32'd0;
      w0_q      <= 32'd0;
      w1_q      <= 32'd0;
      bubble_q  <= 32'd0;
      overlap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q   <= block_type_e'(block_type_i);
        start0_q <= block0_start_i;
        start1_q <= block1_start_i;
        len0_q   <= block0_length_i;
        len1_q   <= block1_length_i;
        npu_q    <= npu_capability_i;
        cim_q    <= in_pipeline_cim_capability_i;
        thr_q    <= bubble_threshold_i;
      end
      if (load0_fire) w0_q <= config_mem_read_data_i;
      if (load1_fire) w1_q <= config_mem_read_data_i;
      if (state_q == StCalc) begin
        bubble_q  <= est_bubble;
        overlap_q <= est_overlap;
      end
    end
  end

  assign bubble_o  = bubble_q;
  assign overlap_o = overlap_q;

endmodule

// File: tb/tb_inter_layer_block_scheduler.sv
// Bench for inter_layer_block_scheduler: directed table, randomized model checks, wait/busy/reset cases.
module tb_inter_layer_block_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] npu_capability_i;
  logic [31:0] in_pipeline_cim_capability_i;
  logic [31:0] bubble_threshold_i;
  logic [31:0] config_mem_addr_o;
  logic        config_mem_read_valid_o;
  logic [31:0] config_mem_read_data_i;
  logic        config_mem_read_ready_i;
  logic [1:0]  block_type_i;
  logic [31:0] block0_start_i, block1_start_i;
  logic [31:0] block0_length_i, block1_length_i;
  logic        schedule_valid_i;
  logic        schedule_ready_o;
  logic        result_valid_o;
  logic        overlap_o;
  logic [31:0] bubble_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  inter_layer_block_scheduler dut (
    .clk_i                        (clk_i),
    .rst_ni                       (rst_ni),
    .npu_capability_i             (npu_capability_i),
    .in_pipeline_cim_capability_i (in_pipeline_cim_capability_i),
    .bubble_threshold_i           (bubble_threshold_i),
    .config_mem_addr_o            (config_mem_addr_o),
    .config_mem_read_valid_o      (config_mem_read_valid_o),
    .config_mem_read_data_i       (config_mem_read_data_i),
    .config_mem_read_ready_i      (config_mem_read_ready_i),
    .block_type_i                 (block_type_i),
    .block0_start_i               (block0_start_i),
    .block1_start_i               (block1_start_i),
    .block0_length_i              (block0_length_i),
    .block1_length_i              (block1_length_i),
    .schedule_valid_i             (schedule_valid_i),
    .schedule_ready_o             (schedule_ready_o),
    .result_valid_o               (result_valid_o),
    .overlap_o                    (overlap_o),
    .bubble_o                     (bubble_o)
  );

  typedef struct {
    logic [1:0]  btype;
    logic [31:0] s0, s1, d0, d1, npu, cim, thr;
    logic [31:0] exp_b;
    logic        exp_o;
    int          wait0, wait1;
    bit          busy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Spec-level reference: absolute product difference, clipped to 32 bits.
  function automatic void model(input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] npu, input logic [31:0] cim,
                                input logic [31:0] thr, output logic [31:0] b, output logic ov);
    longint unsigned a, c, d;
    a = longint'(w0) * longint'(cim);
    c = longint'(w1) * longint'(npu);
    d = (a > c) ? a - c : c - a;
    b = (d > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
    ov = (b <= thr);
  endfunction

  task automatic do_read(input string tag, input logic [31:0] exp_addr, input logic [31:0] data,
                         input int waits, input bit busy);
    for (int i = 0; i <= waits; i++) begin
      check({tag, ".rd_valid"}, config_mem_read_valid_o, 1);
      check({tag, ".rd_addr"}, config_mem_addr_o, exp_addr);
      check({tag, ".sched_ready_busy"}, schedule_ready_o, 0);
      if (busy) begin
        block0_start_i = $urandom;
        block1_start_i = $urandom;
        npu_capability_i = $urandom;
      end
      config_mem_read_ready_i = (i == waits);
      config_mem_read_data_i  = (i == waits) ? data : $urandom;
      @(negedge clk_i);
    end
    config_mem_read_ready_i = 1'b0;
  endtask

  task automatic run(input string tag, input vec_t v);
    @(negedge clk_i);
    check({tag, ".sched_ready"}, schedule_ready_o, 1);
    block_type_i = v.btype;
    block0_start_i = v.s0;
    block1_start_i = v.s1;
    block0_length_i = $urandom;
    block1_length_i = $urandom;
    npu_capability_i = v.npu;
    in_pipeline_cim_capability_i = v.cim;
    bubble_threshold_i = v.thr;
    schedule_valid_i = 1'b1;
    @(negedge clk_i);
    if (!v.busy) schedule_valid_i = 1'b0;
    do_read({tag, ".ld0"}, v.s0, v.d0, v.wait0, v.busy);
    do_read({tag, ".ld1"}, v.s1, v.d1, v.wait1, v.busy);
    schedule_valid_i = 1'b0;
    check({tag, ".calc_rvalid"}, result_valid_o, 0);
    check({tag, ".calc_rdvalid"}, config_mem_read_valid_o, 0);
    check({tag, ".calc_addr"}, config_mem_addr_o, 0);
    @(negedge clk_i);
    check({tag, ".done_rvalid"}, result_valid_o, 1);
    check({tag, ".bubble"}, bubble_o, v.exp_b);
    check({tag, ".overlap"}, overlap_o, v.exp_o);
    @(negedge clk_i);
    check({tag, ".idle_rvalid"}, result_valid_o, 0);
    check({tag, ".bubble_hold"}, bubble_o, v.exp_b);
    check({tag, ".overlap_hold"}, overlap_o, v.exp_o);
  endtask

  initial begin
    vec_t v;
    logic [31:0] eb;
    logic        eo;

    vecs[0] = '{2'd0, 32'd4, 32'd0, 32'd222, 32'd333, 32'd3, 32'd1, 32'd2000, 32'd777, 1'b1, 0, 0, 1'b0};
    vecs[1] = '{2'd1, 32'd0, 32'd4, 32'd111, 32'd777, 32'd3, 32'd1, 32'd2000, 32'd2220, 1'b0, 0, 0, 1'b0};
    vecs[2] = '{2'd2, 32'd8, 32'd12, 32'd444, 32'd999, 32'd3, 32'd1, 32'd2000, 32'd2553, 1'b0, 0, 1, 1'b0};
    vecs[3] = '{2'd3, 32'd16, 32'd20, 32'd1111, 32'd2222, 32'd3, 32'd1, 32'd2000, 32'd5555, 1'b0, 3, 0, 1'b1};
    vecs[4] = '{2'd0, 32'd24, 32'd28, 32'd2000, 32'd0, 32'd3, 32'd1, 32'd2000, 32'd2000, 1'b1, 0, 0, 1'b0};
    vecs[5] = '{2'd0, 32'd24, 32'd28, 32'd2000, 32'd0, 32'd3, 32'd1, 32'd1999, 32'd2000, 1'b0, 0, 0, 1'b0};
    vecs[6] = '{2'd1, 32'd32, 32'd36, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd2, 32'd2000,
                32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0};
    vecs[7] = '{2'd2, 32'd40, 32'd44, 32'd0, 32'd0, 32'd7, 32'd9, 32'd0, 32'd0, 1'b1, 1, 2, 1'b0};

    rst_ni = 1'b0;
    npu_capability_i = '0;
    in_pipeline_cim_capability_i = '0;
    bubble_threshold_i = '0;
    config_mem_read_data_i = '0;
    config_mem_read_ready_i = 1'b0;
    block_type_i = '0;
    block0_start_i = '0;
    block1_start_i = '0;
    block0_length_i = '0;
    block1_length_i = '0;
    schedule_valid_i = 1'b0;

    repeat (2) @(negedge clk_i);
    check("rst.addr", config_mem_addr_o, 0);
    check("rst.rd_valid", config_mem_read_valid_o, 0);
    check("rst.sched_ready", schedule_ready_o, 1);
    check("rst.rvalid", result_valid_o, 0);
    check("rst.overlap", overlap_o, 0);
    check("rst.bubble", bubble_o, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) run($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 24; i++) begin
      v.btype = 2'($urandom_range(0, 3));
      v.s0 = $urandom;
      v.s1 = $urandom;
      v.d0 = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 5000));
      v.d1 = (i % 3 == 1) ? $urandom : 32'($urandom_range(0, 5000));
      v.npu = (i % 4 == 0) ? $urandom : 32'($urandom_range(0, 8));
      v.cim = (i % 4 == 1) ? $urandom : 32'($urandom_range(0, 8));
      v.thr = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 20000));
      model(v.d0, v.d1, v.npu, v.cim, v.thr, eb, eo);
      v.exp_b = eb;
      v.exp_o = eo;
      v.wait0 = $urandom_range(0, 2);
      v.wait1 = $urandom_range(0, 2);
      v.busy = 1'($urandom_range(0, 1));
      run($sformatf("rnd%0d", i), v);
    end

    // Abort in LOAD1: outputs must drop to reset values without waiting for a clock edge.
    @(negedge clk_i);
    block0_start_i = 32'd100;
    block1_start_i = 32'd104;
    npu_capability_i = 32'd1;
    in_pipeline_cim_capability_i = 32'd1;
    bubble_threshold_i = 32'd0;
    schedule_valid_i = 1'b1;
    @(negedge clk_i);
    schedule_valid_i = 1'b0;
    config_mem_read_ready_i = 1'b1;
    config_mem_read_data_i = 32'd5;
    @(negedge clk_i);
    config_mem_read_ready_i = 1'b0;
    check("abort.in_load1_addr", config_mem_addr_o, 104);
    #2 rst_ni = 1'b0;
    #1;
    check("abort.addr", config_mem_addr_o, 0);
    check("abort.rd_valid", config_mem_read_valid_o, 0);
    check("abort.sched_ready", schedule_ready_o, 1);
    check("abort.rvalid", result_valid_o, 0);
    check("abort.overlap", overlap_o, 0);
    check("abort.bubble", bubble_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("abort.no_pulse", result_valid_o, 0);
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("post_abort.no_pulse", result_valid_o, 0);
      check("post_abort.idle", schedule_ready_o, 1);
    end

    run("post_abort.vec0", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
